// File: rtl/tv_pkg.sv
// Shared widths, thresholds and types for the TV-input target tracker.
package tv_pkg;

  localparam int COORD_W = 11;
  localparam int COLOR_W = 10;

  localparam logic [COLOR_W-1:0] R_MIN_DEF = 10'd768;
  localparam logic [COLOR_W-1:0] G_MAX_DEF = 10'd256;
  localparam logic [COLOR_W-1:0] B_MAX_DEF = 10'd256;

  typedef enum logic [1:0] {
    S_WAIT_FRAME = 2'd0,
    S_SEARCH     = 2'd1,
    S_TRACK      = 2'd2
  } state_e;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COLOR_W-1:0] r;
    logic [COLOR_W-1:0] g;
    logic [COLOR_W-1:0] b;
  } pixel_t;

  typedef struct packed {
    logic [COORD_W-1:0] xmin;
    logic [COORD_W-1:0] xmax;
    logic [COORD_W-1:0] ymin;
    logic [COORD_W-1:0] ymax;
  } box_t;

endpackage

// File: rtl/color_match.sv
// Combinational colour-window test: strong red, weak green and blue.
module color_match
  import tv_pkg::*;
#(
  parameter logic [COLOR_W-1:0] R_MIN = R_MIN_DEF,
  parameter logic [COLOR_W-1:0] G_MAX = G_MAX_DEF,
  parameter logic [COLOR_W-1:0] B_MAX = B_MAX_DEF
) (
  input  logic [COLOR_W-1:0] r,
  input  logic [COLOR_W-1:0] g,
  input  logic [COLOR_W-1:0] b,
  output logic               match
);

  assign match = (r >= R_MIN) && (g <= G_MAX) && (b <= B_MAX);

endmodule

// File: rtl/color_target_detector.sv
// Finds the first colour-window match per frame, tracks the match bounding box
// and count, and publishes the previous frame's statistics at each frame start.
module color_target_detector
  import tv_pkg::*;
#(
  parameter logic [COLOR_W-1:0] R_MIN = R_MIN_DEF,
  parameter logic [COLOR_W-1:0] G_MAX = G_MAX_DEF,
  parameter logic [COLOR_W-1:0] B_MAX = B_MAX_DEF,
  parameter int                 CNT_W = 20
) (
  input  logic               clock,
  input  logic               resetN,
  input  logic               enable,
  input  logic               pix_valid,
  input  logic [COORD_W-1:0] data_x,
  input  logic [COORD_W-1:0] data_y,
  input  logic [COLOR_W-1:0] data_R,
  input  logic [COLOR_W-1:0] data_G,
  input  logic [COLOR_W-1:0] data_B,
  output logic               go,
  output logic               newFrame,
  output logic [COORD_W-1:0] x_out,
  output logic [COORD_W-1:0] y_out,
  output logic [COLOR_W-1:0] R_out,
  output logic [COLOR_W-1:0] G_out,
  output logic [COLOR_W-1:0] B_out,
  output logic               found,
  output logic [COORD_W-1:0] box_xmin,
  output logic [COORD_W-1:0] box_xmax,
  output logic [COORD_W-1:0] box_ymin,
  output logic [COORD_W-1:0] box_ymax,
  output logic [CNT_W-1:0]   match_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  logic             go_q, go_d, nf_q, nf_d;
  pixel_t           out_q, out_d, pend_pix_q, pend_pix_d;
  logic             pend_q, pend_d;
  box_t             acc_box_q, acc_box_d, pub_box_q, pub_box_d;
  logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d, pub_cnt_q, pub_cnt_d;
  logic             found_q, found_d;

  pixel_t cur;
  box_t   first_box;
  logic   color_hit, hit, sof;

  color_match #(.R_MIN(R_MIN), .G_MAX(G_MAX), .B_MAX(B_MAX)) u_match (
    .r     (data_R),
    .g     (data_G),
    .b     (data_B),
    .match (color_hit)
  );

  assign cur       = {data_x, data_y, data_R, data_G, data_B};
  assign first_box = {data_x, data_x, data_y, data_y};
  assign hit       = pix_valid && color_hit;
  assign sof       = pix_valid && (data_x == '0) && (data_y == '0);

  always_comb begin
    state_d    = state_q;
    go_d       = 1'b0;
    nf_d       = 1'b0;
    out_d      = out_q;
    pend_d     = 1'b0;
    pend_pix_d = pend_pix_q;
    acc_box_d  = acc_box_q;
    acc_cnt_d  = acc_cnt_q;
    found_d    = found_q;
    pub_box_d  = pub_box_q;
    pub_cnt_d  = pub_cnt_q;

    if (!enable) begin
      state_d   = S_WAIT_FRAME;
      acc_box_d = '0;
      acc_cnt_d = '0;
    end else begin
      if (pend_q) begin
        go_d  = 1'b1;
        out_d = pend_pix_q;
      end
      if (sof) begin
        if (state_q != S_WAIT_FRAME) begin
          nf_d      = 1'b1;
          found_d   = (state_q == S_TRACK);
          pub_box_d = (state_q == S_TRACK) ? acc_box_q : '0;
          pub_cnt_d = (state_q == S_TRACK) ? acc_cnt_q : '0;
        end
        state_d   = S_SEARCH;
        acc_box_d = '0;
        acc_cnt_d = '0;
        if (hit) begin
          state_d   = S_TRACK;
          acc_box_d = first_box;
          acc_cnt_d = CNT_W'(1);
          // A match on the frame-start pixel is reported one cycle after newFrame.
          if (state_q == S_WAIT_FRAME) begin
            go_d  = 1'b1;
            out_d = cur;
          end else begin
            pend_d     = 1'b1;
            pend_pix_d = cur;
          end
        end
      end else if (hit) begin
        case (state_q)
          S_SEARCH: begin
            go_d      = 1'b1;
            out_d     = cur;
            state_d   = S_TRACK;
            acc_box_d = first_box;
            acc_cnt_d = CNT_W'(1);
          end
          S_TRACK: begin
            acc_box_d.xmin = (data_x < acc_box_q.xmin) ? data_x : acc_box_q.xmin;
            acc_box_d.xmax = (data_x > acc_box_q.xmax) ? data_x : acc_box_q.xmax;
            acc_box_d.ymin = (data_y < acc_box_q.ymin) ? data_y : acc_box_q.ymin;
            acc_box_d.ymax = (data_y > acc_box_q.ymax) ? data_y : acc_box_q.ymax;
            if (acc_cnt_q != CNT_MAX) acc_cnt_d = acc_cnt_q + CNT_W'(1);
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q    <= S_WAIT_FRAME;
      go_q       <= 1'b0;
      nf_q       <= 1'b0;
      out_q      <= '0;
      pend_q     <= 1'b0;
      pend_pix_q <= '0;
      acc_box_q  <= '0;
      acc_cnt_q  <= '0;
      found_q    <= 1'b0;
      pub_box_q  <= '0;
      pub_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      go_q       <= go_d;
      nf_q       <= nf_d;
      out_q      <= out_d;
      pend_q     <= pend_d;
      pend_pix_q <= pend_pix_d;
      acc_box_q  <= acc_box_d;
      acc_cnt_q  <= acc_cnt_d;
      found_q    <= found_d;
      pub_box_q  <= pub_box_d;
      pub_cnt_q  <= pub_cnt_d;
    end
  end

  assign go          = go_q;
  assign newFrame    = nf_q;
  assign x_out       = out_q.x;
  assign y_out       = out_q.y;
  assign R_out       = out_q.r;
  assign G_out       = out_q.g;
  assign B_out       = out_q.b;
  assign found       = found_q;
  assign box_xmin    = pub_box_q.xmin;
  assign box_xmax    = pub_box_q.xmax;
  assign box_ymin    = pub_box_q.ymin;
  assign box_ymax    = pub_box_q.ymax;
  assign match_count = pub_cnt_q;

endmodule

// File: tb/tb_color_target_detector.sv
// Directed bench for color_target_detector: table of frames plus enable/reset sequences.
module tb_color_target_detector;

  logic        clock = 1'b0;
  logic        resetN = 1'b0;
  logic        enable = 1'b0;
  logic        pix_valid = 1'b0;
  logic [10:0] data_x = '0, data_y = '0;
  logic [9:0]  data_R = '0, data_G = '0, data_B = '0;

  logic        go, newFrame, found;
  logic [10:0] x_out, y_out, box_xmin, box_xmax, box_ymin, box_ymax;
  logic [9:0]  R_out, G_out, B_out;
  logic [19:0] match_count;

  logic        go4, newFrame4, found4;
  logic [10:0] x_out4, y_out4, box_xmin4, box_xmax4, box_ymin4, box_ymax4;
  logic [9:0]  R_out4, G_out4, B_out4;
  logic [3:0]  match_count4;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clock = ~clock;

  color_target_detector dut (
    .clock(clock), .resetN(resetN), .enable(enable), .pix_valid(pix_valid),
    .data_x(data_x), .data_y(data_y), .data_R(data_R), .data_G(data_G), .data_B(data_B),
    .go(go), .newFrame(newFrame), .x_out(x_out), .y_out(y_out),
    .R_out(R_out), .G_out(G_out), .B_out(B_out), .found(found),
    .box_xmin(box_xmin), .box_xmax(box_xmax), .box_ymin(box_ymin), .box_ymax(box_ymax),
    .match_count(match_count)
  );

  color_target_detector #(.CNT_W(4)) dut4 (
    .clock(clock), .resetN(resetN), .enable(enable), .pix_valid(pix_valid),
    .data_x(data_x), .data_y(data_y), .data_R(data_R), .data_G(data_G), .data_B(data_B),
    .go(go4), .newFrame(newFrame4), .x_out(x_out4), .y_out(y_out4),
    .R_out(R_out4), .G_out(G_out4), .B_out(B_out4), .found(found4),
    .box_xmin(box_xmin4), .box_xmax(box_xmax4), .box_ymin(box_ymin4), .box_ymax(box_ymax4),
    .match_count(match_count4)
  );

  typedef struct {
    int fid; int w; int h;
    bit exp_nf; int go_idx; int gx; int gy;
    bit found; int bx0; int bx1; int by0; int by1; int cnt; int cnt4;
  } frame_t;

  frame_t frames[8];

  localparam logic [29:0] C_HIT  = {10'd900, 10'd100, 10'd50};
  localparam logic [29:0] C_MISS = {10'd100, 10'd100, 10'd100};

  function automatic logic [29:0] pix_color(int fid, int x, int y, int w);
    case (fid)
      0, 1, 2: return (x == 2 && y == 1) ? C_HIT : C_MISS;
      3: return ((x == 1 && y == 0) || (x == 3 && y == 2) || (x == 0 && y == 3)) ? C_HIT : C_MISS;
      4: begin
        if (x == 0 && y == 0) return C_HIT;
        if (x == 1 && y == 0) return {10'd767, 10'd0, 10'd0};
        if (x == 2 && y == 0) return {10'd768, 10'd256, 10'd256};
        if (x == 3 && y == 0) return {10'd768, 10'd257, 10'd0};
        if (x == 0 && y == 1) return {10'd768, 10'd0, 10'd257};
        return C_MISS;
      end
      6: return (y * w + x < 20) ? C_HIT : C_MISS;
      default: return C_MISS;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step(input bit v, input int x, input int y, input logic [29:0] c);
    @(negedge clock);
    pix_valid = v;
    data_x = 11'(x);
    data_y = 11'(y);
    {data_R, data_G, data_B} = c;
    @(posedge clock);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " go"}, go, 0);
    chk({tag, " newFrame"}, newFrame, 0);
    chk({tag, " found"}, found, 0);
    chk({tag, " x_out"}, x_out, 0);
    chk({tag, " y_out"}, y_out, 0);
    chk({tag, " rgb"}, {R_out, G_out, B_out}, 0);
    chk({tag, " box"}, {box_xmin, box_xmax, box_ymin, box_ymax}, 0);
    chk({tag, " count"}, match_count, 0);
    chk({tag, " count4"}, match_count4, 0);
  endtask

  initial begin
    frames[0] = '{0, 4, 4, 1'b0, 6, 2, 1, 1'b0, 0, 0, 0, 0, 0, 0};
    frames[1] = '{1, 4, 4, 1'b1, 6, 2, 1, 1'b1, 2, 2, 1, 1, 1, 1};
    frames[2] = '{2, 4, 4, 1'b1, 6, 2, 1, 1'b1, 2, 2, 1, 1, 1, 1};
    frames[3] = '{3, 4, 4, 1'b1, 1, 1, 0, 1'b1, 2, 2, 1, 1, 1, 1};
    frames[4] = '{4, 4, 4, 1'b1, 1, 0, 0, 1'b1, 0, 3, 0, 3, 3, 3};
    frames[5] = '{5, 4, 4, 1'b1, -1, 0, 0, 1'b1, 0, 2, 0, 0, 2, 2};
    frames[6] = '{6, 8, 4, 1'b1, 1, 0, 0, 1'b0, 0, 0, 0, 0, 0, 0};
    frames[7] = '{7, 4, 1, 1'b1, -1, 0, 0, 1'b1, 0, 7, 0, 2, 20, 15};

    enable = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk_zero("reset");
    @(negedge clock);
    resetN = 1'b1;

    for (int f = 0; f < 8; f++) begin
      for (int p = 0; p < frames[f].w * frames[f].h; p++) begin
        int x, y;
        string t;
        x = p % frames[f].w;
        y = p / frames[f].w;
        t = $sformatf("f%0d p%0d", f, p);
        step(1'b1, x, y, pix_color(frames[f].fid, x, y, frames[f].w));
        chk({t, " go"}, go, int'(p == frames[f].go_idx));
        chk({t, " go4"}, go4, int'(p == frames[f].go_idx));
        chk({t, " newFrame"}, newFrame, int'(p == 0 && frames[f].exp_nf));
        if (p == 0) begin
          chk({t, " found"}, found, frames[f].found);
          chk({t, " xmin"}, box_xmin, frames[f].bx0);
          chk({t, " xmax"}, box_xmax, frames[f].bx1);
          chk({t, " ymin"}, box_ymin, frames[f].by0);
          chk({t, " ymax"}, box_ymax, frames[f].by1);
          chk({t, " count"}, match_count, frames[f].cnt);
          chk({t, " count4"}, match_count4, frames[f].cnt4);
        end
        if (p == frames[f].go_idx) begin
          chk({t, " x_out"}, x_out, frames[f].gx);
          chk({t, " y_out"}, y_out, frames[f].gy);
          chk({t, " R_out"}, R_out, 900);
          chk({t, " G_out"}, G_out, 100);
          chk({t, " B_out"}, B_out, 50);
        end
      end
    end

    // Enter S_TRACK mid-frame, then drop enable for five cycles.
    step(1'b1, 1, 1, C_MISS);
    step(1'b1, 2, 1, C_HIT);
    chk("pre-en go", go, 1);
    chk("pre-en x_out", x_out, 2);
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 3, 1, C_HIT);
      chk($sformatf("en_low%0d go", i), go, 0);
      chk($sformatf("en_low%0d newFrame", i), newFrame, 0);
      chk($sformatf("en_low%0d x_out", i), x_out, 2);
      chk($sformatf("en_low%0d found", i), found, 1);
      chk($sformatf("en_low%0d count", i), match_count, 20);
    end
    enable = 1'b1;
    step(1'b1, 3, 2, C_HIT);
    chk("en_back midframe go", go, 0);
    step(1'b1, 0, 0, C_MISS);
    chk("en_back sof newFrame", newFrame, 0);
    step(1'b1, 1, 0, C_HIT);
    chk("en_back go", go, 1);
    chk("en_back x_out", x_out, 1);
    chk("en_back y_out", y_out, 0);
    chk("en_back count hold", match_count, 20);

    // Asynchronous reset pulse mid-frame.
    @(negedge clock);
    resetN = 1'b0;
    #1;
    chk_zero("midreset");
    @(negedge clock);
    resetN = 1'b1;
    step(1'b1, 2, 2, C_HIT);
    chk("post_reset midframe go", go, 0);
    step(1'b1, 0, 0, C_MISS);
    chk("post_reset sof newFrame", newFrame, 0);
    step(1'b1, 1, 0, C_HIT);
    chk("post_reset go", go, 1);
    chk("post_reset x_out", x_out, 1);
    step(1'b0, 2, 0, C_HIT);
    chk("idle go", go, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
